// File: rtl/ltc_access_arbiter.sv
// Arbitrates per-requester read/write strobes onto a single local-time-counter
// req/ack handshake: writes first, round-robin within a class, with per-phase timeouts.
module ltc_access_arbiter #(
    parameter int P_LTC_WIDTH = 49,
    parameter int P_N_REQ     = 3,
    parameter int P_TIMEOUT   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [P_N_REQ-1:0]               rd_stb,
    input  logic [P_N_REQ-1:0]               wr_stb,
    input  logic [P_N_REQ*P_LTC_WIDTH-1:0]   wr_data,
    output logic [P_N_REQ-1:0]               busy,
    output logic [P_N_REQ-1:0]               done,
    output logic [P_N_REQ-1:0]               err,
    output logic [P_LTC_WIDTH-1:0]           rd_data,
    output logic [P_LTC_WIDTH-1:0]           ltc_wr_data,
    output logic                             ltc_wr_req,
    input  logic                             ltc_wr_ack,
    input  logic [P_LTC_WIDTH-1:0]           ltc_rd_data,
    output logic                             ltc_rd_req,
    input  logic                             ltc_rd_ack
);

    localparam int W  = P_LTC_WIDTH;
    localparam int N  = P_N_REQ;
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(P_TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(N - 1);

    typedef enum logic [2:0] {IDLE, ARB, REQ_HI, SETTLE, REQ_LO, FIN} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    pend_rd, pend_wr;
    logic [W-1:0]    hold [N];
    logic [GW-1:0]   last_grant;
    logic            op_wr;
    logic            abort;
    logic [TW-1:0]   timer;

    logic [GW-1:0]   sel_idx;
    logic            sel_wr;
    logic            cur_ack;
    logic            timed_out;
    logic            req_keep;
    logic            req_kind_wr;

    // First set bit of mask scanning upward from last+1, wrapping at N.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] mask,
                                               input logic [GW-1:0] last);
        int idx;
        rr_pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(last) + 1 + k;
            if (idx >= N) idx = idx - N;
            if (mask[idx]) rr_pick = idx[GW-1:0];
        end
    endfunction

    always_comb begin
        sel_wr      = |pend_wr;
        sel_idx     = rr_pick(sel_wr ? pend_wr : pend_rd, last_grant);
        cur_ack     = op_wr ? ltc_wr_ack : ltc_rd_ack;
        timed_out   = (timer == T_LAST);
        req_kind_wr = (state == ARB) ? sel_wr : op_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if ((|pend_rd || |pend_wr) && !ltc_wr_ack && !ltc_rd_ack) state_nxt = ARB;
            ARB:     state_nxt = REQ_HI;
            REQ_HI:  if (cur_ack) state_nxt = SETTLE;
                     else if (timed_out) state_nxt = REQ_LO;
            SETTLE:  state_nxt = REQ_LO;
            REQ_LO:  if (!cur_ack || timed_out) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        req_keep = (state_nxt == REQ_HI) || (state_nxt == SETTLE);
    end

    // During ARB last_grant still names the previous winner; the new winner is
    // already covered by its pending bit, so ARB is excluded from the grant term.
    always_comb begin
        done = '0;
        err  = '0;
        busy = pend_rd | pend_wr;
        for (int i = 0; i < N; i++) begin
            if (last_grant == GW'(i)) begin
                if (state == FIN) begin
                    done[i] = !abort;
                    err[i]  = abort;
                end
                if (state != IDLE && state != ARB) busy[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_rd     <= '0;
            pend_wr     <= '0;
            for (int i = 0; i < N; i++) hold[i] <= '0;
            last_grant  <= LAST_INIT;
            op_wr       <= 1'b0;
            abort       <= 1'b0;
            timer       <= '0;
            rd_data     <= '0;
            ltc_wr_data <= '0;
            ltc_wr_req  <= 1'b0;
            ltc_rd_req  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend_wr[i]) begin
                    if (state == ARB && sel_wr && sel_idx == GW'(i)) pend_wr[i] <= 1'b0;
                end else if (wr_stb[i]) begin
                    pend_wr[i] <= 1'b1;
                    hold[i]    <= wr_data[i*W +: W];
                end
                if (pend_rd[i]) begin
                    if (state == ARB && !sel_wr && sel_idx == GW'(i)) pend_rd[i] <= 1'b0;
                end else if (rd_stb[i]) begin
                    pend_rd[i] <= 1'b1;
                end
            end

            timer <= (state_nxt != state) ? '0 : timer + TW'(1);

            if (state == ARB) begin
                last_grant <= sel_idx;
                op_wr      <= sel_wr;
                abort      <= 1'b0;
                if (sel_wr) ltc_wr_data <= hold[sel_idx];
            end
            if ((state == REQ_HI && state_nxt == REQ_LO) ||
                (state == REQ_LO && cur_ack && timed_out))
                abort <= 1'b1;
            if (state == SETTLE && !op_wr) rd_data <= ltc_rd_data;

            ltc_wr_req <= req_keep && req_kind_wr;
            ltc_rd_req <= req_keep && !req_kind_wr;
        end
    end

endmodule

// File: tb/tb_ltc_access_arbiter.sv
// Self-checking bench: vector table plus scoreboard queue of expected done/err
// pulses, with a one-cycle-ack counter model on the LTC handshake.
module tb_ltc_access_arbiter;

    localparam int W = 49;
    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     rd_stb = '0;
    logic [N-1:0]     wr_stb = '0;
    logic [N*W-1:0]   wr_data = '0;
    logic [N-1:0]     busy, done, err;
    logic [W-1:0]     rd_data, ltc_wr_data, ltc_rd_data;
    logic             ltc_wr_req, ltc_rd_req;
    logic             ltc_wr_ack = 1'b0;
    logic             ltc_rd_ack = 1'b0;
    logic [W-1:0]     ltc_val = 49'h100;
    bit               stuck_rd = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [N-1:0] done_v;
        logic [N-1:0] err_v;
        logic [W-1:0] rd;
        bit           chk_w;
        logic [W-1:0] wdat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic [W-1:0] wd [N];
        int           n;
        int           idx [3];
        bit           isw [3];
    } vec_t;
    vec_t vecs [6];

    logic [W-1:0] exp_rd  = '0;
    logic [W-1:0] exp_ltc = 49'h100;

    ltc_access_arbiter #(.P_LTC_WIDTH(W), .P_N_REQ(N), .P_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .rd_stb(rd_stb), .wr_stb(wr_stb), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .rd_data(rd_data),
        .ltc_wr_data(ltc_wr_data), .ltc_wr_req(ltc_wr_req), .ltc_wr_ack(ltc_wr_ack),
        .ltc_rd_data(ltc_rd_data), .ltc_rd_req(ltc_rd_req), .ltc_rd_ack(ltc_rd_ack)
    );

    always #5 clk = ~clk;

    // Counter model: acks follow req by one cycle; a write loads the counter.
    assign ltc_rd_data = ltc_val;
    always @(posedge clk) begin
        ltc_rd_ack <= ltc_rd_req && !stuck_rd;
        ltc_wr_ack <= ltc_wr_req;
        if (ltc_wr_req) ltc_val <= ltc_wr_data;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic pushExp(input logic [N-1:0] d, input logic [N-1:0] e, input logic [W-1:0] r,
                           input bit cw, input logic [W-1:0] wd);
        exp_t x;
        x.done_v = d; x.err_v = e; x.rd = r; x.chk_w = cw; x.wdat = wd;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ltc_wr_req || ltc_rd_req)
                checkOutput("req_exclusive", 64'(ltc_wr_req & ltc_rd_req), 64'd0);
            if (done != '0 || err != '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_pulse", 64'({done, err}), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("done", 64'(done), 64'(e.done_v));
                    checkOutput("err", 64'(err), 64'(e.err_v));
                    checkOutput("rd_data", 64'(rd_data), 64'(e.rd));
                    if (e.chk_w) checkOutput("ltc_wr_data", 64'(ltc_wr_data), 64'(e.wdat));
                end
            end
        end
    end

    function automatic vec_t mkv(input logic [N-1:0] rd, input logic [N-1:0] wr,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                                 input int n, input int i0, input bit w0, input int i1, input bit w1,
                                 input int i2, input bit w2);
        mkv.rd = rd; mkv.wr = wr;
        mkv.wd[0] = a; mkv.wd[1] = b; mkv.wd[2] = c;
        mkv.n = n;
        mkv.idx[0] = i0; mkv.isw[0] = w0;
        mkv.idx[1] = i1; mkv.isw[1] = w1;
        mkv.idx[2] = i2; mkv.isw[2] = w2;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        @(negedge clk);
        rd_stb  = rd;
        wr_stb  = wr;
        wr_data = {c, b, a};
        @(posedge clk);
        #1;
        rd_stb = '0;
        wr_stb = '0;
        checkOutput("busy_after_strobe", 64'(busy), 64'(rd | wr));
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 300 && sbq.size() != 0; c++) @(negedge clk);
        if (sbq.size() != 0) begin
            checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        repeat (3) @(negedge clk);
        checkOutput("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int hi;
        bit seen;
        vec_t v;
        logic [N-1:0] oh;

        vecs[0] = mkv(3'b001, 3'b000, '0, '0, '0, 1, 0, 0, 0, 0, 0, 0);
        vecs[1] = mkv(3'b111, 3'b000, '0, '0, '0, 3, 1, 0, 2, 0, 0, 0);
        vecs[2] = mkv(3'b000, 3'b010, '0, 49'h1_0000_0000_0000, '0, 1, 1, 1, 0, 0, 0, 0);
        vecs[3] = mkv(3'b001, 3'b100, '0, '0, 49'h1234, 2, 2, 1, 0, 0, 0, 0);
        vecs[4] = mkv(3'b000, 3'b111, 49'h0AAAA, 49'h0BBBB, 49'h0CCCC, 3, 1, 1, 2, 1, 0, 1);
        vecs[5] = mkv(3'b010, 3'b000, '0, '0, '0, 1, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done_err", 64'({done, err}), 64'd0);
        checkOutput("rst_reqs", 64'({ltc_wr_req, ltc_rd_req}), 64'd0);
        checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
        checkOutput("rst_ltc_wr_data", 64'(ltc_wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            for (int j = 0; j < v.n; j++) begin
                oh = N'(1) << v.idx[j];
                if (v.isw[j]) begin
                    exp_ltc = v.wd[v.idx[j]];
                    pushExp(oh, '0, exp_rd, 1'b1, v.wd[v.idx[j]]);
                end else begin
                    exp_rd = exp_ltc;
                    pushExp(oh, '0, exp_rd, 1'b0, '0);
                end
            end
            applyStimulus(v.rd, v.wr, v.wd[0], v.wd[1], v.wd[2]);
            waitDrain();
        end

        // Latency: strobe sampled at cycle 0 must give done in cycle 8.
        exp_rd = exp_ltc;
        pushExp(3'b100, '0, exp_rd, 1'b0, '0);
        @(negedge clk);
        rd_stb = 3'b100;
        @(posedge clk);
        #1;
        rd_stb = '0;
        lat = 1;
        while (done == '0 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency_cycle", 64'(lat), 64'd8);
        waitDrain();

        // Read ack stuck low: req held 16 cycles, err pulse, rd_data kept.
        stuck_rd = 1'b1;
        pushExp('0, 3'b001, exp_rd, 1'b0, '0);
        applyStimulus(3'b001, 3'b000, '0, '0, '0);
        hi = 0;
        for (int c = 0; c < 80 && sbq.size() != 0; c++) begin
            @(negedge clk);
            if (ltc_rd_req) hi++;
        end
        checkOutput("timeout_req_cycles", 64'(hi), 64'd16);
        checkOutput("timeout_rd_data", 64'(rd_data), 64'(exp_rd));
        stuck_rd = 1'b0;
        waitDrain();

        // Reset while the read request is in flight; strobe in the reset cycle is dropped.
        applyStimulus(3'b001, 3'b000, '0, '0, '0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = ltc_rd_req;
        end
        checkOutput("rd_req_reached", 64'(seen), 64'd1);
        rst     = 1'b1;
        wr_stb  = 3'b010;
        wr_data = {49'h0, 49'h1_2345, 49'h0};
        @(posedge clk);
        #1;
        checkOutput("midrst_reqs", 64'({ltc_wr_req, ltc_rd_req}), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done_err", 64'({done, err}), 64'd0);
        checkOutput("midrst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        wr_stb = '0;
        exp_rd = '0;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);

        exp_rd = exp_ltc;
        pushExp(3'b100, '0, exp_rd, 1'b0, '0);
        applyStimulus(3'b100, 3'b000, '0, '0, '0);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
